// File: rtl/bcd_gray_pkg.sv
// ---------------------------------------------------------------------------
// bcd_gray_pkg
// Shared definitions for the BCD/Gray converter and its digit serializer:
// digit width, largest legal BCD value, mode encodings and a 4-bit
// Gray-to-binary helper.
// ---------------------------------------------------------------------------
package bcd_gray_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned MAX_BCD = 9;

  localparam logic MODE_BCD  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  typedef logic [DIGIT_W-1:0] digit_t;

  // MSB passes through; each lower bit is the running XOR from the top.
  function automatic digit_t gray2bin4(input digit_t g);
    digit_t b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/bcd_digit_serializer_if.sv
// ---------------------------------------------------------------------------
// bcd_digit_serializer_if
// Bundles the word-in and digit-out handshakes of bcd_digit_serializer.
//   in_valid/in_ready/in_word/in_mode : packed word input stream
//   out_valid/out_ready               : digit output handshake
//   out_code/out_mode/out_idx         : current digit, captured mode, index
//   out_last/out_err/word_err         : last digit, digit error, word error
// Modports: master = producer/consumer side (bench), slave = serializer.
// ---------------------------------------------------------------------------
interface bcd_digit_serializer_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  import bcd_gray_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                          in_valid;
  logic                          in_ready;
  logic [DIGIT_W*NUM_DIGITS-1:0] in_word;
  logic                          in_mode;
  logic                          out_valid;
  logic                          out_ready;
  digit_t                        out_code;
  logic                          out_mode;
  logic [IDX_W-1:0]              out_idx;
  logic                          out_last;
  logic                          out_err;
  logic                          word_err;

  modport master (
    output in_valid, in_word, in_mode, out_ready,
    input  in_ready, out_valid, out_code, out_mode, out_idx, out_last, out_err, word_err
  );

  modport slave (
    input  in_valid, in_word, in_mode, out_ready,
    output in_ready, out_valid, out_code, out_mode, out_idx, out_last, out_err, word_err
  );

endinterface

// File: rtl/bcd_digit_check.sv
// ---------------------------------------------------------------------------
// bcd_digit_check
// Combinational validity check of one digit.
//   i_digit : 4-bit digit
//   i_mode  : 0 = BCD, 1 = Gray
//   o_err   : digit (decoded to binary in Gray mode) exceeds 9
// ---------------------------------------------------------------------------
module bcd_digit_check
  import bcd_gray_pkg::*;
(
  input  digit_t i_digit,
  input  logic   i_mode,
  output logic   o_err
);

  digit_t w_bin;

  assign w_bin = (i_mode == MODE_GRAY) ? gray2bin4(i_digit) : i_digit;
  assign o_err = (w_bin > digit_t'(MAX_BCD));

endmodule

// File: rtl/bcd_digit_serializer.sv
// ---------------------------------------------------------------------------
// bcd_digit_serializer
// Accepts a packed multi-digit word with a mode bit and emits it one digit
// per cycle, most-significant digit first, flagging invalid digits.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_digit_serializer_if (word in, digits out)
// ---------------------------------------------------------------------------
module bcd_digit_serializer
  import bcd_gray_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_digit_serializer_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned WORD_W = DIGIT_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]        r_state;
  logic [WORD_W-1:0] r_shift;
  logic              r_mode;
  logic [IDX_W-1:0]  r_idx;
  logic              r_acc;

  logic   w_valid;
  logic   w_last;
  logic   w_out_hs;
  logic   w_in_ready;
  logic   w_accept;
  logic   w_err;
  digit_t w_digit;

  assign w_valid    = (r_state == ST_SEND);
  assign w_last     = w_valid && (r_idx == '0);
  assign w_out_hs   = w_valid && bus.out_ready;
  // A new word may land on the same edge the last digit leaves.
  assign w_in_ready = (r_state == ST_IDLE) || (w_out_hs && w_last);
  assign w_accept   = bus.in_valid && w_in_ready;
  // The current digit always sits at the top of the shift register.
  assign w_digit    = r_shift[WORD_W-1 -: DIGIT_W];

  bcd_digit_check u_check (
    .i_digit (w_digit),
    .i_mode  (r_mode),
    .o_err   (w_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_mode  <= MODE_BCD;
      r_idx   <= '0;
      r_acc   <= 1'b0;
    end else if (w_accept) begin
      r_state <= ST_SEND;
      r_shift <= bus.in_word;
      r_mode  <= bus.in_mode;
      r_idx   <= IDX_TOP;
      r_acc   <= 1'b0;
    end else if (w_out_hs) begin
      if (w_last) begin
        r_state <= ST_IDLE;
      end else begin
        r_idx   <= r_idx - 1'b1;
        r_shift <= r_shift << DIGIT_W;
        r_acc   <= r_acc | w_err;
      end
    end
  end

  // Outputs are forced to zero while idle so nothing stale leaks out.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_code  = w_valid ? w_digit : '0;
  assign bus.out_mode  = w_valid & r_mode;
  assign bus.out_idx   = w_valid ? r_idx : '0;
  assign bus.out_last  = w_last;
  assign bus.out_err   = w_valid & w_err;
  assign bus.word_err  = w_last & (r_acc | w_err);

endmodule

// File: tb/tb_bcd_digit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_serializer
// Self-checking bench: scoreboard of expected digits built from each accepted
// word, a table of words with known per-digit error masks, hand-written
// back-to-back / stall / mid-word-reset sequences and a randomized phase.
// ---------------------------------------------------------------------------
module tb_bcd_digit_serializer;

  localparam int unsigned N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_digit_serializer_if #(.NUM_DIGITS(N)) bus ();

  bcd_digit_serializer #(.NUM_DIGITS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fails++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] code;
    logic       mode;
    int         idx;
    logic       last;
    logic       err;
    logic       werr;
  } exp_t;

  exp_t q[$];

  function automatic logic digit_bad(input int d, input logic m);
    int v;
    v = m ? (d ^ (d >> 1) ^ (d >> 2) ^ (d >> 3)) : d;
    return v > 9;
  endfunction

  function automatic void push_word(input logic [4*N-1:0] w, input logic m);
    exp_t e;
    logic acc = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      e.code = 4'((w >> (4 * k)) & 'hF);
      e.mode = m;
      e.idx  = k;
      e.last = (k == 0);
      e.err  = digit_bad(int'(e.code), m);
      acc    = acc | e.err;
      e.werr = acc;
      q.push_back(e);
    end
  endfunction

  logic [N-1:0] obs_mask;
  logic         obs_werr;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy;
    if (!rst_n) begin
      q.delete();
    end else begin
      exp_rdy = (q.size() == 0) || (bus.out_ready && q[0].last);
      check("in_ready", bus.in_ready, exp_rdy);
      if (q.size() == 0) begin
        check("idle_valid", bus.out_valid, 1'b0);
      end else begin
        e = q[0];
        check("out_valid", bus.out_valid, 1'b1);
        check("out_code", bus.out_code, e.code);
        check("out_mode", bus.out_mode, e.mode);
        check("out_idx", bus.out_idx, e.idx);
        check("out_last", bus.out_last, e.last);
        check("out_err", bus.out_err, e.err);
        if (e.last) check("word_err", bus.word_err, e.werr);
        if (bus.out_ready) begin
          obs_mask[e.idx] = bus.out_err;
          if (e.last) obs_werr = bus.word_err;
          void'(q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) push_word(bus.in_word, bus.in_mode);
    end
  end

  // ---------------- drivers ----------------
  task automatic send_word(input logic [4*N-1:0] w, input logic m);
    int t;
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    bus.in_mode  = m;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (t == 200) fail_now("send_timeout");
    else begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid) break;
    end
    if (t == 400) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [4*N-1:0] word;
    logic           mode;
    logic [N-1:0]   err_mask;
    logic           werr;
  } vec_t;

  vec_t vecs[9];
  int   stall_rdy[6]  = '{1, 0, 0, 1, 1, 1};
  int   stall_code[6] = '{4, 3, 3, 3, 2, 1};
  int   stall_irdy[6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 4'b0000, 1'b0};
    vecs[1] = '{16'h12A4, 1'b0, 4'b0010, 1'b1};
    vecs[2] = '{16'h0000, 1'b0, 4'b0000, 1'b0};
    vecs[3] = '{16'hF00D, 1'b1, 4'b1000, 1'b1};
    vecs[4] = '{16'h9876, 1'b0, 4'b0000, 1'b0};
    vecs[5] = '{16'hFA9B, 1'b0, 4'b1101, 1'b1};
    vecs[6] = '{16'h8888, 1'b1, 4'b1111, 1'b1};
    vecs[7] = '{16'h0123, 1'b1, 4'b0000, 1'b0};
    vecs[8] = '{16'h7C5A, 1'b1, 4'b0001, 1'b1};

    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_code", bus.out_code, 4'h0);
    check("rst_out_mode", bus.out_mode, 1'b0);
    check("rst_out_idx", bus.out_idx, 0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_out_err", bus.out_err, 1'b0);
    check("rst_word_err", bus.word_err, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table of words with known error masks.
    for (int i = 0; i < 9; i++) begin
      obs_mask = '0;
      obs_werr = 1'b0;
      send_word(vecs[i].word, vecs[i].mode);
      wait_idle();
      check("vec_err_mask", obs_mask, vecs[i].err_mask);
      check("vec_word_err", obs_werr, vecs[i].werr);
    end

    // Back-to-back words: no bubble, new word taken on the digit-6 cycle.
    send_word(16'h9876, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_word  = 16'h0505;
    bus.in_mode  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_valid", bus.out_valid, 1'b1);
      if (i == 3) begin
        check("b2b_code6", bus.out_code, 4'h6);
        check("b2b_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
      end
    end
    wait_idle();

    // Downstream stalls freeze the current digit.
    send_word(16'h4321, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = 1'(stall_rdy[i]);
      @(negedge clk);
      check("stall_code", bus.out_code, stall_code[i]);
      check("stall_in_ready", bus.in_ready, stall_irdy[i]);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a word.
    send_word(16'h5678, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_code", bus.out_code, 4'h7);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 1'b0);
    check("mid_rst_idx", bus.out_idx, 0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    obs_mask = '1;
    send_word(16'h1111, 1'b0);
    @(negedge clk);
    check("post_rst_idx", bus.out_idx, 3);
    check("post_rst_code", bus.out_code, 4'h1);
    wait_idle();
    check("post_rst_mask", obs_mask, 4'b0000);

    // Randomized words, gaps and backpressure against the model.
    rand_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [4*N-1:0] w;
      logic           m;
      w = (4*N)'($urandom);
      m = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_word(w, m);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    wait_idle();
    check("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
